// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the pipeline hazard controller.
//   - FSM state encodings (typed enum plus plain constants for legacy code)
//   - exec-stage forwarding source selects
package hazard_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MISS_WAIT = 2'd1;
  localparam logic [1:0] ST_RESUME    = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    MISS_WAIT = ST_MISS_WAIT,
    RESUME    = ST_RESUME
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   i_clk    clock
//   i_arst   asynchronous active-high reset (clears count)
//   i_inc    count this cycle
//   o_cnt    current count
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)                r_cnt <= '0;
    else if (i_inc && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the fetch/decode/exec pipeline.
//   Inputs : decode/exec register addresses, exec load and taken-branch flags,
//            mem/wb write-back info, cache miss request and refill-done pulse.
//   Outputs: o_stall_fetch/decode/back, o_flush_decode/exec, o_forward_rs1/rs2,
//            saturating stall/flush cycle counters, sticky miss watchdog flag.
// A cache miss freezes the whole pipe (MISS_WAIT) until i_mem_ready; the cycle
// after refill (RESUME) evaluates load-use/redirect again on the held exec stage.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_WIDTH    = 32,
  parameter int MISS_TIMEOUT = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
  input  logic                  i_load_instr_exec,
  input  logic                  i_pc_src_exec,
  input  logic                  i_reg_we_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
  input  logic                  i_reg_we_wb,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
  input  logic                  i_cache_miss,
  input  logic                  i_mem_ready,
  output logic                  o_stall_fetch,
  output logic                  o_stall_decode,
  output logic                  o_stall_back,
  output logic                  o_flush_decode,
  output logic                  o_flush_exec,
  output logic [1:0]            o_forward_rs1,
  output logic [1:0]            o_forward_rs2,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_flush_cnt,
  output logic                  o_miss_timeout
);

  localparam int WD_W = $clog2(MISS_TIMEOUT + 1);

  logic [1:0]      r_state, w_state_nxt;
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  logic       w_freeze, w_lu, w_redirect;
  logic       w_stall_fetch, w_stall_decode, w_stall_back;
  logic       w_flush_decode, w_flush_exec;
  logic [1:0] w_fwd1, w_fwd2;

  // ---------------- forwarding (mem beats wb, x0 never forwarded)
  always_comb begin
    w_fwd1 = FWD_RF;
    if (i_reg_we_mem && i_rd_addr_mem != '0 && i_rd_addr_mem == i_rs1_addr_exec)
      w_fwd1 = FWD_MEM;
    else if (i_reg_we_wb && i_rd_addr_wb != '0 && i_rd_addr_wb == i_rs1_addr_exec)
      w_fwd1 = FWD_WB;

    w_fwd2 = FWD_RF;
    if (i_reg_we_mem && i_rd_addr_mem != '0 && i_rd_addr_mem == i_rs2_addr_exec)
      w_fwd2 = FWD_MEM;
    else if (i_reg_we_wb && i_rd_addr_wb != '0 && i_rd_addr_wb == i_rs2_addr_exec)
      w_fwd2 = FWD_WB;
  end

  // ---------------- hazard detection
  // Freeze covers the miss-request cycle itself so nothing advances before
  // MISS_WAIT is entered.
  assign w_freeze = (r_state == ST_MISS_WAIT) ||
                    (r_state == ST_IDLE && i_cache_miss);

  assign w_lu = i_load_instr_exec && i_rd_addr_exec != '0 &&
                (i_rd_addr_exec == i_rs1_addr_dec || i_rd_addr_exec == i_rs2_addr_dec);

  assign w_redirect = i_pc_src_exec && !w_freeze;

  always_comb begin
    w_stall_fetch  = 1'b0;
    w_stall_decode = 1'b0;
    w_stall_back   = 1'b0;
    w_flush_decode = 1'b0;
    w_flush_exec   = 1'b0;
    if (w_freeze) begin
      w_stall_fetch  = 1'b1;
      w_stall_decode = 1'b1;
      w_stall_back   = 1'b1;
    end else if (w_redirect) begin
      // the instruction waiting on the load is on the wrong path anyway
      w_flush_decode = 1'b1;
      w_flush_exec   = 1'b1;
    end else if (w_lu) begin
      w_stall_fetch  = 1'b1;
      w_stall_decode = 1'b1;
      w_flush_exec   = 1'b1;
    end
  end

  // ---------------- miss FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (i_cache_miss) w_state_nxt = ST_MISS_WAIT;
      ST_MISS_WAIT: if (i_mem_ready)  w_state_nxt = ST_RESUME;
      ST_RESUME:    w_state_nxt = i_cache_miss ? ST_MISS_WAIT : ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state   <= ST_IDLE;
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != ST_MISS_WAIT && w_state_nxt == ST_MISS_WAIT) begin
        r_wd <= '0;
      end else if (r_state == ST_MISS_WAIT) begin
        // hold at the limit so a long wait cannot wrap the watchdog
        if (r_wd != WD_W'(MISS_TIMEOUT)) r_wd <= r_wd + WD_W'(1);
        if (r_wd == WD_W'(MISS_TIMEOUT - 1)) r_timeout <= 1'b1;
      end
    end
  end

  // ---------------- statistics
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .i_inc  (w_stall_fetch | w_stall_decode | w_stall_back),
    .o_cnt  (o_stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .i_inc  (w_flush_exec),
    .o_cnt  (o_flush_cnt)
  );

  // ---------------- outputs (quiet while reset is held)
  assign o_stall_fetch  = w_stall_fetch  & ~i_arst;
  assign o_stall_decode = w_stall_decode & ~i_arst;
  assign o_stall_back   = w_stall_back   & ~i_arst;
  assign o_flush_decode = w_flush_decode & ~i_arst;
  assign o_flush_exec   = w_flush_exec   & ~i_arst;
  assign o_forward_rs1  = i_arst ? FWD_RF : w_fwd1;
  assign o_forward_rs2  = i_arst ? FWD_RF : w_fwd2;
  assign o_miss_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations.
// Small counters (4 bit) and a short watchdog (8) keep boundaries reachable.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int MT = 8;

  logic          i_clk = 1'b0;
  logic          i_arst;
  logic [AW-1:0] i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec;
  logic [AW-1:0] i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb;
  logic          i_load_instr_exec, i_pc_src_exec, i_reg_we_mem, i_reg_we_wb;
  logic          i_cache_miss, i_mem_ready;
  logic          o_stall_fetch, o_stall_decode, o_stall_back, o_flush_decode, o_flush_exec;
  logic [1:0]    o_forward_rs1, o_forward_rs2;
  logic [CW-1:0] o_stall_cnt, o_flush_cnt;
  logic          o_miss_timeout;

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  hazard_ctrl #(.REG_ADDR_W(AW), .CNT_WIDTH(CW), .MISS_TIMEOUT(MT)) dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_rs1_addr_dec(i_rs1_addr_dec), .i_rs2_addr_dec(i_rs2_addr_dec),
    .i_rs1_addr_exec(i_rs1_addr_exec), .i_rs2_addr_exec(i_rs2_addr_exec),
    .i_rd_addr_exec(i_rd_addr_exec), .i_load_instr_exec(i_load_instr_exec),
    .i_pc_src_exec(i_pc_src_exec), .i_reg_we_mem(i_reg_we_mem),
    .i_rd_addr_mem(i_rd_addr_mem), .i_reg_we_wb(i_reg_we_wb),
    .i_rd_addr_wb(i_rd_addr_wb), .i_cache_miss(i_cache_miss),
    .i_mem_ready(i_mem_ready),
    .o_stall_fetch(o_stall_fetch), .o_stall_decode(o_stall_decode),
    .o_stall_back(o_stall_back), .o_flush_decode(o_flush_decode),
    .o_flush_exec(o_flush_exec), .o_forward_rs1(o_forward_rs1),
    .o_forward_rs2(o_forward_rs2), .o_stall_cnt(o_stall_cnt),
    .o_flush_cnt(o_flush_cnt), .o_miss_timeout(o_miss_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // {stall_fetch, stall_decode, stall_back, flush_decode, flush_exec}
  function automatic logic [4:0] ctl();
    return {o_stall_fetch, o_stall_decode, o_stall_back, o_flush_decode, o_flush_exec};
  endfunction

  task automatic clr_in();
    i_rs1_addr_dec = '0; i_rs2_addr_dec = '0; i_rs1_addr_exec = '0; i_rs2_addr_exec = '0;
    i_rd_addr_exec = '0; i_rd_addr_mem = '0; i_rd_addr_wb = '0;
    i_load_instr_exec = 0; i_pc_src_exec = 0; i_reg_we_mem = 0; i_reg_we_wb = 0;
    i_cache_miss = 0; i_mem_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge i_clk); clr_in(); i_arst = 1;
    @(negedge i_clk); i_arst = 0;
  endtask

  initial begin
    clr_in();
    i_arst = 1;
    #1;
    chk("rst_ctl", 32'(ctl()), 32'h0);
    chk("rst_stallcnt", 32'(o_stall_cnt), 0);
    chk("rst_timeout", 32'(o_miss_timeout), 0);
    @(negedge i_clk); i_arst = 0;

    // ---- forwarding
    @(negedge i_clk);
    i_reg_we_mem = 1; i_rd_addr_mem = 5; i_reg_we_wb = 1; i_rd_addr_wb = 5;
    i_rs1_addr_exec = 5; i_rs2_addr_exec = 7; #1;
    chk("fwd_mem", 32'(o_forward_rs1), 32'h2);
    chk("fwd_rs2_none", 32'(o_forward_rs2), 32'h0);
    i_rd_addr_mem = 0; #1;
    chk("fwd_wb", 32'(o_forward_rs1), 32'h1);
    i_rd_addr_wb = 0; #1;
    chk("fwd_rf", 32'(o_forward_rs1), 32'h0);
    i_rd_addr_wb = 7; i_rd_addr_mem = 7; i_reg_we_mem = 0; #1;
    chk("fwd_rs2_wb_we_mem0", 32'(o_forward_rs2), 32'h1);
    clr_in();

    // ---- load-use for exactly one cycle
    @(negedge i_clk);
    i_load_instr_exec = 1; i_rd_addr_exec = 3; i_rs2_addr_dec = 3; #1;
    chk("lu_ctl", 32'(ctl()), 32'b11001);
    @(negedge i_clk); i_load_instr_exec = 0; #1;
    chk("lu_gone", 32'(ctl()), 32'h0);
    chk("lu_stallcnt", 32'(o_stall_cnt), 1);
    chk("lu_flushcnt", 32'(o_flush_cnt), 1);
    i_load_instr_exec = 1; i_rd_addr_exec = 0; i_rs2_addr_dec = 0; #1;
    chk("lu_x0", 32'(ctl()), 32'h0);
    // load-use plus redirect: redirect wins
    i_rd_addr_exec = 3; i_rs1_addr_dec = 3; i_pc_src_exec = 1; #1;
    chk("lu_redirect", 32'(ctl()), 32'b00011);

    // ---- miss freeze with branch held: 1 IDLE + 11 MISS_WAIT stall cycles
    do_reset();
    @(negedge i_clk); i_cache_miss = 1; i_pc_src_exec = 1; #1;
    chk("miss_req_ctl", 32'(ctl()), 32'b11100);
    for (int k = 1; k <= 11; k++) begin
      @(negedge i_clk); i_cache_miss = 0; i_mem_ready = (k == 11); #1;
      chk($sformatf("miss_wait_ctl%0d", k), 32'(ctl()), 32'b11100);
    end
    @(negedge i_clk); i_mem_ready = 0; #1;
    chk("resume_ctl", 32'(ctl()), 32'b00011);
    chk("resume_stallcnt", 32'(o_stall_cnt), 12);
    chk("resume_flushcnt", 32'(o_flush_cnt), 0);
    @(negedge i_clk); i_pc_src_exec = 0; #1;
    chk("idle_ctl", 32'(ctl()), 32'h0);
    chk("idle_flushcnt", 32'(o_flush_cnt), 1);
    // 5 more load-use stalls: 12 -> saturates at 15
    i_load_instr_exec = 1; i_rd_addr_exec = 4; i_rs1_addr_dec = 4;
    repeat (5) @(negedge i_clk);
    i_load_instr_exec = 0; #1;
    chk("stallcnt_sat", 32'(o_stall_cnt), 15);
    chk("flushcnt_6", 32'(o_flush_cnt), 6);

    // ---- watchdog
    do_reset();
    @(negedge i_clk); i_cache_miss = 1;
    @(negedge i_clk); i_cache_miss = 0;   // now in MISS_WAIT
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk); #1;
      chk($sformatf("wd_after%0d", k), 32'(o_miss_timeout), (k >= 8) ? 1 : 0);
    end
    chk("wd_still_frozen", 32'(ctl()), 32'b11100);
    i_mem_ready = 1;
    @(negedge i_clk); i_mem_ready = 0; #1;
    chk("wd_resume_ctl", 32'(ctl()), 32'h0);
    chk("wd_sticky", 32'(o_miss_timeout), 1);

    // ---- reset mid-miss
    do_reset();
    @(negedge i_clk); i_cache_miss = 1;
    @(negedge i_clk); i_cache_miss = 0;
    i_reg_we_mem = 1; i_rd_addr_mem = 9; i_rs1_addr_exec = 9; #1;
    chk("pre_arst_ctl", 32'(ctl()), 32'b11100);
    i_arst = 1; #1;
    chk("arst_ctl", 32'(ctl()), 32'h0);
    chk("arst_fwd", 32'(o_forward_rs1), 32'h0);
    chk("arst_stallcnt", 32'(o_stall_cnt), 0);
    @(negedge i_clk); i_arst = 0; i_mem_ready = 1; #1;
    chk("post_arst_ctl", 32'(ctl()), 32'h0);
    chk("post_arst_fwd", 32'(o_forward_rs1), 32'h2);
    @(negedge i_clk); i_mem_ready = 0; #1;
    chk("post_arst_idle", 32'(ctl()), 32'h0);
    chk("post_arst_stallcnt", 32'(o_stall_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
